fir_ctrl: RTL and testbench

Sequencer and stream adapter for the 9-tap FIR datapath. It loads coefficients through a valid/ready port and, after each load, flushes the sample history with zeros. It then streams samples into the FIR, captures each result at fixed latency into a small result FIFO, and presents results on a valid/ready output. Sits between the Avalon-facing glue and the FIR instance, and owns all of the FIR's control, enable, b and x inputs.

---
 rtl/fir_ctrl.sv | 217 +++++++++++++++++++++
 tb/tb_fir_ctrl.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_ctrl.sv
// fir_ctrl: sequencer and stream adapter in front of a TAPS-tap FIR datapath.
// Loads coefficients, flushes history with zeros, streams samples and buffers results.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   cfg_start           pulse: begin a coefficient reload (honoured in IDLE and RUN)
//   cfg_busy            high in DRAIN, LOAD or FLUSH
//   coef_loaded         high in RUN
//   coef_valid/ready    coefficient handshake, coef_data word 0 becomes tap 0
//   in_valid/ready      sample handshake, in_data is the sample
//   out_valid/ready     result handshake, out_data is the result FIFO head
//   fir_control         0 = coefficient shift, 1 = sample shift
//   fir_enable          one-cycle strobe per coefficient/sample/flush word
//   fir_b, fir_x        coefficient and sample words to the FIR
//   fir_data_out        FIR result, captured 3 cycles after sample acceptance
module fir_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int TAPS       = 9,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cfg_start,
    output logic                  cfg_busy,
    output logic                  coef_loaded,
    input  logic                  coef_valid,
    input  logic [DATA_WIDTH-1:0] coef_data,
    output logic                  coef_ready,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    input  logic                  out_ready,
    output logic                  fir_control,
    output logic                  fir_enable,
    output logic [DATA_WIDTH-1:0] fir_b,
    output logic [DATA_WIDTH-1:0] fir_x,
    input  logic [DATA_WIDTH-1:0] fir_data_out
);

    localparam int KW = $clog2(TAPS + 1);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int OW = CW + 1;

    typedef enum logic [2:0] {
        IDLE,
        DRAIN,
        LOAD,
        FLUSH,
        RUN
    } state_t;

    state_t state;
    state_t state_next;

    logic [KW-1:0]         coef_cnt;
    logic [KW-1:0]         flush_cnt;
    logic [2:0]            tag;
    logic [1:0]            inflight;
    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [CW-1:0]         fifo_count;
    logic [OW-1:0]         occupancy;
    logic                  push;
    logic                  pop;
    logic                  coef_hs;
    logic                  sample_hs;
    logic                  credit_ok;

    logic                  en_d;
    logic                  ctl_d;
    logic [DATA_WIDTH-1:0] b_d;
    logic [DATA_WIDTH-1:0] x_d;

    // Tags ride alongside the FIR pipeline; leaving stage 2 means the
    // FIR output now belongs to that sample.
    assign inflight = 2'(tag[0]) + 2'(tag[1]) + 2'(tag[2]);
    assign push     = tag[2];

    assign out_valid = (fifo_count != '0);
    assign pop       = out_valid & out_ready;
    assign out_data  = mem[rd_ptr];

    // The head leaving this cycle frees its slot, which is what lets a
    // 4-deep FIFO sustain one sample per cycle behind a 3-stage pipeline.
    assign occupancy = OW'(fifo_count) + OW'(inflight);
    assign credit_ok = (occupancy - OW'(pop)) < OW'(FIFO_DEPTH);

    assign cfg_busy    = (state == DRAIN) | (state == LOAD) | (state == FLUSH);
    assign coef_loaded = (state == RUN);
    assign coef_ready  = (state == LOAD);
    assign in_ready    = (state == RUN) & credit_ok & ~cfg_start;

    assign coef_hs   = coef_valid & coef_ready;
    assign sample_hs = in_valid & in_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (cfg_start) state_next = DRAIN;
            end
            DRAIN: begin
                if (inflight == 2'd0) state_next = LOAD;
            end
            LOAD: begin
                if (coef_hs && coef_cnt == KW'(TAPS - 1)) state_next = FLUSH;
            end
            FLUSH: begin
                if (flush_cnt == KW'(TAPS - 1)) state_next = RUN;
            end
            RUN: begin
                if (cfg_start) state_next = DRAIN;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            coef_cnt  <= '0;
            flush_cnt <= '0;
        end else begin
            if (state != LOAD && state_next == LOAD) begin
                coef_cnt <= '0;
            end else if (coef_hs) begin
                coef_cnt <= coef_cnt + KW'(1);
            end
            if (state != FLUSH && state_next == FLUSH) begin
                flush_cnt <= '0;
            end else if (state == FLUSH) begin
                flush_cnt <= flush_cnt + KW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tag <= '0;
        end else begin
            tag <= {tag[1:0], sample_hs};
        end
    end

    // FIR drive: enable is a one-cycle strobe, the data fields hold.
    always_comb begin
        en_d  = 1'b0;
        ctl_d = fir_control;
        b_d   = fir_b;
        x_d   = fir_x;
        if (coef_hs) begin
            en_d  = 1'b1;
            ctl_d = 1'b0;
            b_d   = coef_data;
        end else if (state == FLUSH) begin
            en_d  = 1'b1;
            ctl_d = 1'b1;
            x_d   = '0;
        end else if (sample_hs) begin
            en_d  = 1'b1;
            ctl_d = 1'b1;
            x_d   = in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fir_enable  <= 1'b0;
            fir_control <= 1'b0;
            fir_b       <= '0;
            fir_x       <= '0;
        end else begin
            fir_enable  <= en_d;
            fir_control <= ctl_d;
            fir_b       <= b_d;
            fir_x       <= x_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && push) begin
            mem[wr_ptr] <= fir_data_out;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == AW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == AW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + AW'(1);
            end
            unique case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

endmodule

// File: tb/tb_fir_ctrl.sv
// tb_fir_ctrl: scoreboard bench for fir_ctrl with a behavioural 9-tap FIR.
// Stimulus pushes hand-computed results; a monitor pops them on each output handshake.
module tb_fir_ctrl;

    localparam int DW    = 32;
    localparam int TAPS  = 9;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          cfg_start;
    logic          cfg_busy;
    logic          coef_loaded;
    logic          coef_valid;
    logic [DW-1:0] coef_data;
    logic          coef_ready;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_ready;
    logic          fir_control;
    logic          fir_enable;
    logic [DW-1:0] fir_b;
    logic [DW-1:0] fir_x;
    logic [DW-1:0] fir_data_out;

    fir_ctrl #(
        .DATA_WIDTH(DW),
        .TAPS(TAPS),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .reset(reset),
        .cfg_start(cfg_start),
        .cfg_busy(cfg_busy),
        .coef_loaded(coef_loaded),
        .coef_valid(coef_valid),
        .coef_data(coef_data),
        .coef_ready(coef_ready),
        .in_valid(in_valid),
        .in_data(in_data),
        .in_ready(in_ready),
        .out_valid(out_valid),
        .out_data(out_data),
        .out_ready(out_ready),
        .fir_control(fir_control),
        .fir_enable(fir_enable),
        .fir_b(fir_b),
        .fir_x(fir_x),
        .fir_data_out(fir_data_out)
    );

    always #5 clk = ~clk;

    // Behavioural FIR: coefficients shift toward tap 0 so the first word
    // loaded lands on tap 0; samples enter at tap 0; output registered.
    logic [DW-1:0] m_coef [TAPS];
    logic [DW-1:0] m_hist [TAPS];
    logic [DW-1:0] m_sum;

    always_comb begin
        m_sum = '0;
        for (int i = 0; i < TAPS; i++) m_sum = m_sum + m_coef[i] * m_hist[i];
    end

    always @(posedge clk) begin
        if (fir_enable) begin
            if (!fir_control) begin
                for (int i = 0; i < TAPS - 1; i++) m_coef[i] <= m_coef[i+1];
                m_coef[TAPS-1] <= fir_b;
            end else begin
                for (int i = 1; i < TAPS; i++) m_hist[i] <= m_hist[i-1];
                m_hist[0] <= fir_x;
            end
        end
        fir_data_out <= m_sum;
    end

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    int pop_cnt = 0;
    int first_valid_cyc = 0;
    int first_pop = 0;
    int last_pop = 0;
    int last_acc = 0;
    int pops_at_ready = 0;
    logic [DW-1:0] exp_q [$];

    logic [DW-1:0] bp_vals [6] = '{2, 3, 4, 5, 6, 7};
    logic [DW-1:0] bp_exps [6] = '{10, 12, 15, 19, 24, 30};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Monitor: negedge sampling; inputs only change just after posedge.
    always @(negedge clk) begin
        if (!reset) begin
            if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    $display("FAIL unexpected_out: got %0d expected none", out_data);
                end else begin
                    chk("out_data", out_data, exp_q.pop_front());
                end
                pop_cnt++;
                if (first_pop < 0) first_pop = cyc;
                last_pop = cyc;
            end
        end
    end

    task automatic send(input logic [DW-1:0] d, input logic [DW-1:0] e,
                        output int stalls);
        logic ok;
        ok = 1'b0;
        stalls = 0;
        in_valid = 1'b1;
        in_data = d;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
            stalls++;
        end
        if (ok) begin
            exp_q.push_back(e);
            last_acc = cyc + 1;
            @(posedge clk);
            #1;
        end
        chk("send_accepted", DW'(ok), 1);
        in_valid = 1'b0;
    endtask

    task automatic send1(input logic [DW-1:0] d, input logic [DW-1:0] e);
        int st;
        send(d, e, st);
    endtask

    task automatic load_words(input int base, input int step, input int n);
        logic ok;
        for (int i = 0; i < n; i++) begin
            ok = 1'b0;
            coef_valid = 1'b1;
            coef_data = DW'(base + step * i);
            for (int k = 0; k < 200; k++) begin
                @(negedge clk);
                if (coef_ready) begin
                    ok = 1'b1;
                    break;
                end
            end
            if (i == 0) pops_at_ready = pop_cnt;
            if (!ok) begin
                chk("coef_accepted", DW'(ok), 1);
                break;
            end
            @(posedge clk);
            #1;
        end
        coef_valid = 1'b0;
    endtask

    task automatic pulse_cfg();
        cfg_start = 1'b1;
        @(posedge clk);
        #1;
        cfg_start = 1'b0;
    endtask

    task automatic wait_run();
        logic ok;
        ok = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (coef_loaded) begin
                ok = 1'b1;
                break;
            end
        end
        chk("reach_run", DW'(ok), 1);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain();
        logic ok;
        ok = 1'b0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !out_valid) begin
                ok = 1'b0 | 1'b1;
                break;
            end
        end
        chk("drained", DW'(ok), 1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int st;
        int stall_tot;
        int acc0;
        int pb;
        int idx;

        reset = 1'b1;
        cfg_start = 1'b0;
        coef_valid = 1'b0;
        coef_data = '0;
        in_valid = 1'b0;
        in_data = '0;
        out_ready = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_cfg_busy", DW'(cfg_busy), 0);
        chk("rst_coef_loaded", DW'(coef_loaded), 0);
        chk("rst_coef_ready", DW'(coef_ready), 0);
        chk("rst_in_ready", DW'(in_ready), 0);
        chk("rst_out_valid", DW'(out_valid), 0);
        chk("rst_fir_enable", DW'(fir_enable), 0);
        chk("rst_fir_control", DW'(fir_control), 0);
        chk("rst_fir_b", fir_b, 0);
        chk("rst_fir_x", fir_x, 0);
        reset = 1'b0;

        // Samples offered in IDLE are never taken
        in_valid = 1'b1;
        in_data = 77;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("idle_in_ready", DW'(in_ready), 0);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("idle_out_valid", DW'(out_valid), 0);

        // Impulse through coefs 1..9
        pulse_cfg();
        load_words(1, 1, 9);
        wait_run();
        first_valid_cyc = -1;
        send1(1, 1);
        acc0 = last_acc;
        for (int k = 1; k < 9; k++) send1(0, DW'(k + 1));
        send1(0, 0);
        wait_drain();
        chk("impulse_latency", DW'(first_valid_cyc - acc0), 3);

        // Throughput with all-ones coefficients
        pulse_cfg();
        load_words(1, 0, 9);
        wait_run();
        first_pop = -1;
        pb = pop_cnt;
        stall_tot = 0;
        for (int k = 0; k < 12; k++) begin
            send(1, (k < 9) ? DW'(k + 1) : DW'(9), st);
            stall_tot += st;
        end
        chk("tput_stalls", DW'(stall_tot), 0);
        wait_drain();
        chk("tput_count", DW'(pop_cnt - pb), 12);
        chk("tput_span", DW'(last_pop - first_pop), 11);

        // Backpressure: only DEPTH samples fit while out_ready is low
        out_ready = 1'b0;
        idx = 0;
        in_valid = 1'b1;
        in_data = bp_vals[0];
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (in_ready && idx < 6) begin
                exp_q.push_back(bp_exps[idx]);
                idx++;
            end
            @(posedge clk);
            #1;
            if (idx < 6) in_data = bp_vals[idx];
        end
        @(negedge clk);
        chk("bp_accepted", DW'(idx), 4);
        chk("bp_in_ready", DW'(in_ready), 0);
        chk("bp_out_valid", DW'(out_valid), 1);
        chk("bp_head", out_data, 10);
        repeat (3) @(negedge clk);
        chk("bp_head_stable", out_data, 10);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        in_valid = 1'b0;
        send1(6, 24);
        send1(7, 30);
        wait_drain();

        // Reload with three samples in flight
        pb = pop_cnt;
        send1(10, 39);
        send1(20, 58);
        send1(30, 87);
        pulse_cfg();
        chk("reload_busy", DW'(cfg_busy), 1);
        chk("reload_coef_ready", DW'(coef_ready), 0);
        chk("reload_loaded", DW'(coef_loaded), 0);
        load_words(3, 2, 9);
        chk("reload_drained_first", DW'(pops_at_ready - pb), 3);
        wait_run();
        send1(5, 15);
        send1(0, 25);
        wait_drain();

        // Reset in the middle of a load
        pulse_cfg();
        load_words(100, 1, 4);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("midload_coef_ready", DW'(coef_ready), 0);
        chk("midload_busy", DW'(cfg_busy), 0);
        chk("midload_fir_enable", DW'(fir_enable), 0);
        reset = 1'b0;
        pulse_cfg();
        load_words(9, -1, 9);
        wait_run();
        send1(1, 9);
        send1(0, 8);
        send1(0, 7);
        send1(0, 6);
        wait_drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
